// File: rtl/data_sram_responder_pkg.sv
// Shared constants, region-select enum and byte-lane merge helper for data_sram_responder.
package data_sram_responder_pkg;

    localparam logic [31:0] CONF_BASE_ADDR = 32'h1FAF_0000;
    localparam logic [15:0] LED_OFFSET     = 16'hF000;
    localparam logic [15:0] SCRATCH_OFFSET = 16'hF010;
    localparam logic [15:0] TIMER_OFFSET   = 16'hE000;

    localparam logic [31:0] OOR_READ_VALUE = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_LED,
        REG_SCRATCH,
        REG_TIMER,
        REG_NONE
    } region_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  wen);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = wen[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// Core-side data SRAM bus: the core drives the request, the responder returns rdata.
interface data_sram_responder_if;

    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output en,
        output wen,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  en,
        input  wen,
        input  addr,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/sram_bytewrite_ram.sv
// Single-port word RAM, 4 byte enables, read-first with a registered output that holds when idle.
module sram_bytewrite_ram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

    // Read and write share the edge; the read sees the word before this write lands.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: word RAM plus LED/scratch/timer registers in the conf region.
// Optional build macro DATA_SRAM_OOR_ERR_EN adds the sticky oor_err output for out-of-range RAM accesses.
module data_sram_responder #(
    parameter int          DEPTH_LOG2  = 10,
    parameter logic [31:0] CONF_BASE   = data_sram_responder_pkg::CONF_BASE_ADDR,
    parameter logic [15:0] LED_OFF     = data_sram_responder_pkg::LED_OFFSET,
    parameter logic [15:0] SCRATCH_OFF = data_sram_responder_pkg::SCRATCH_OFFSET,
    parameter logic [15:0] TIMER_OFF   = data_sram_responder_pkg::TIMER_OFFSET
) (
    input  logic                         clk,
    input  logic                         rst,
    data_sram_responder_if.slave         bus,
    output logic [15:0]                  led,
    output logic [31:0]                  timer
`ifdef DATA_SRAM_OOR_ERR_EN
    ,
    output logic                         oor_err
`endif
);

    import data_sram_responder_pkg::*;

    region_e     sel;
    logic        wr;
    logic        oor;
    logic        ram_en;
    logic [31:0] ram_q;
    logic [31:0] reg_rd;
    logic [31:0] merged;
    logic [31:0] scratch;
    logic        unused_addr;

    region_e     sel_p1;
    logic [31:0] reg_q_p1;

    // Offsets are matched on the word address; byte-offset bits never select a register.
    function automatic region_e decode(input logic [31:0] a);
        region_e r;
        if (a[31:16] != CONF_BASE[31:16]) begin
            r = REG_RAM;
        end else if (a[15:2] == LED_OFF[15:2]) begin
            r = REG_LED;
        end else if (a[15:2] == SCRATCH_OFF[15:2]) begin
            r = REG_SCRATCH;
        end else if (a[15:2] == TIMER_OFF[15:2]) begin
            r = REG_TIMER;
        end else begin
            r = REG_NONE;
        end
        return r;
    endfunction

    assign sel         = decode(bus.addr);
    assign wr          = bus.en && (bus.wen != 4'b0000) && !rst;
    assign unused_addr = ^bus.addr[1:0];

`ifdef DATA_SRAM_OOR_ERR_EN
    assign oor = (sel == REG_RAM) && (bus.addr[31:DEPTH_LOG2+2] != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            oor_err <= 1'b0;
        end else if (bus.en && oor) begin
            oor_err <= 1'b1;
        end
    end
`else
    assign oor = 1'b0;
`endif

    assign ram_en = bus.en && !rst && !oor && (sel == REG_RAM);

    sram_bytewrite_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (bus.wen),
        .addr  (bus.addr[DEPTH_LOG2+1:2]),
        .wdata (bus.wdata),
        .rdata (ram_q)
    );

    always_comb begin
        reg_rd = 32'h0;
        case (sel)
            REG_LED:     reg_rd = {16'h0, led};
            REG_SCRATCH: reg_rd = scratch;
            REG_TIMER:   reg_rd = timer;
            default:     reg_rd = 32'h0;
        endcase
    end

    // One merge serves every register; LED simply keeps the low half.
    assign merged = byte_merge(reg_rd, bus.wdata, bus.wen);

    always_ff @(posedge clk) begin
        if (rst) begin
            led     <= 16'h0;
            scratch <= 32'h0;
        end else if (wr) begin
            if (sel == REG_LED) begin
                led <= merged[15:0];
            end
            if (sel == REG_SCRATCH) begin
                scratch <= merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= 32'h0;
        end else if (wr && (sel == REG_TIMER)) begin
            timer <= merged;
        end else begin
            timer <= timer + 32'd1;
        end
    end

    // ---- stage p1: capture region and register read data alongside the RAM read ----
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_p1   <= REG_NONE;
            reg_q_p1 <= 32'h0;
        end else if (bus.en) begin
            sel_p1   <= oor ? REG_NONE : sel;
            reg_q_p1 <= oor ? OOR_READ_VALUE : reg_rd;
        end
    end

    assign bus.rdata = (sel_p1 == REG_RAM) ? ram_q : reg_q_p1;

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: a behavioural model predicts each response as it is driven.
module tb_data_sram_responder;

    logic        clk;
    logic        rst;
    logic [15:0] led;
    logic [31:0] timer;
`ifdef DATA_SRAM_OOR_ERR_EN
    logic        oor_err;
`endif

    data_sram_responder_if bus();

    data_sram_responder dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .led   (led),
        .timer (timer)
`ifdef DATA_SRAM_OOR_ERR_EN
        ,
        .oor_err (oor_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] value;
        logic        known;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_ram   [0:1023];
    logic        m_known [0:1023];
    logic [15:0] m_led;
    logic [31:0] m_scratch;
    logic [31:0] m_timer;
    logic [31:0] m_rdata;
    logic        m_rdata_known;
    logic        m_oor;
    logic [31:0] obs;
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_merge(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] w);
        logic [31:0] r;
        r = o;
        if (w[0]) r[7:0]   = n[7:0];
        if (w[1]) r[15:8]  = n[15:8];
        if (w[2]) r[23:16] = n[23:16];
        if (w[3]) r[31:24] = n[31:24];
        return r;
    endfunction

    // One clock: predict, push, drive, clock, pop and compare.
    task automatic step(input logic r, input logic en, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        logic [31:0] old;
        logic [31:0] nw;
        logic [31:0] t_next;
        logic [9:0]  idx;
        logic        is_conf;
        logic        hi_bits;
        logic        suppress;
        logic        known;
        logic [15:0] off;

        idx      = addr[11:2];
        is_conf  = (addr[31:16] == 16'h1FAF);
        off      = {addr[15:2], 2'b00};
        hi_bits  = (addr[31:12] != 20'h0);
        t_next   = m_timer + 32'd1;
        suppress = 1'b0;
        known    = 1'b1;
        old      = 32'h0;

        if (r) begin
            m_rdata = 32'h0; m_rdata_known = 1'b1;
            m_led = 16'h0; m_scratch = 32'h0; m_oor = 1'b0;
            t_next = 32'h0;
        end else if (en) begin
            if (is_conf) begin
                if (off == 16'hF000)      old = {16'h0, m_led};
                else if (off == 16'hF010) old = m_scratch;
                else if (off == 16'hE000) old = m_timer;
                else                      old = 32'h0;
            end else begin
                old   = m_ram[idx];
                known = m_known[idx];
            end
            nw = ref_merge(old, wdata, wen);
`ifdef DATA_SRAM_OOR_ERR_EN
            if (!is_conf && hi_bits) begin
                suppress = 1'b1;
                old      = 32'hDEAD_BEEF;
                known    = 1'b1;
                m_oor    = 1'b1;
            end
`endif
            m_rdata = old; m_rdata_known = known;
            if (wen != 4'h0 && !suppress) begin
                if (is_conf) begin
                    if (off == 16'hF000)      m_led = nw[15:0];
                    else if (off == 16'hF010) m_scratch = nw;
                    else if (off == 16'hE000) t_next = nw;
                end else begin
                    m_ram[idx] = nw;
                    if (wen == 4'hF) m_known[idx] = 1'b1;
                end
            end
        end
        m_timer = t_next;
        e.value = m_rdata;
        e.known = m_rdata_known;
        exp_q.push_back(e);

        rst       = r;
        bus.en    = en;
        bus.wen   = wen;
        bus.addr  = addr;
        bus.wdata = wdata;
        @(posedge clk);
        #1;
        e   = exp_q.pop_front();
        obs = bus.rdata;
        if (e.known) check("rdata", bus.rdata, e.value);
        check("timer", timer, m_timer);
        check("led", {16'h0, led}, {16'h0, m_led});
`ifdef DATA_SRAM_OOR_ERR_EN
        check("oor_err", {31'h0, oor_err}, {31'h0, m_oor});
`endif
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_led = 16'h0; m_scratch = 32'h0; m_timer = 32'h0; m_rdata = 32'h0;
        m_rdata_known = 1'b1; m_oor = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            m_ram[i]   = 32'h0;
            m_known[i] = 1'b0;
        end
        rst = 1'b1;
        bus.en = 1'b0; bus.wen = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0;

        step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        check("reset_timer", timer, 32'h0);

        // LED read right after reset, timer counting up from zero
        step(1'b0, 1'b1, 4'h0, 32'h1FAF_F000, 32'h0);
        check("led_read_reset", obs, 32'h0);
        check("timer_count1", timer, 32'h1);
        idle();
        check("timer_count2", timer, 32'h2);

        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 4'hF, 32'(i * 4), 32'hA5A5_0000 | 32'(i));
        end

        step(1'b0, 1'b1, 4'hF, 32'h0000_0010, 32'h1122_3344);
        check("wr_old", obs, 32'hA5A5_0004);
        step(1'b0, 1'b1, 4'b0001, 32'h0000_0010, 32'h0000_00AA);
        check("wr_partial_old", obs, 32'h1122_3344);
        step(1'b0, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
        check("partial_merge", obs, 32'h1122_33AA);

        step(1'b0, 1'b1, 4'hF, 32'h1FAF_F000, 32'hFFFF_5A5A);
        check("led_value", {16'h0, led}, 32'h0000_5A5A);
        step(1'b0, 1'b1, 4'h0, 32'h1FAF_F000, 32'h0);
        check("led_read", obs, 32'h0000_5A5A);

        step(1'b0, 1'b1, 4'hF, 32'h1FAF_E000, 32'hFFFF_FFFE);
        check("timer_load", timer, 32'hFFFF_FFFE);
        idle();
        check("timer_max", timer, 32'hFFFF_FFFF);
        idle();
        check("timer_wrap", timer, 32'h0);

        step(1'b0, 1'b1, 4'h0, 32'h1FAF_F020, 32'h0);
        check("unmapped_read", obs, 32'h0);

        for (int c = 0; c < 64; c++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 7) == 0) a = 32'h1FAF_F010;
            if (c % 2 == 0) step(1'b0, 1'b1, 4'($urandom_range(1, 15)), a, $urandom);
            else            step(1'b0, 1'b1, 4'h0, a, 32'h0);
        end

        step(1'b0, 1'b1, 4'hF, 32'h0000_0004, 32'h0BAD_F00D);
        step(1'b0, 1'b1, 4'hF, 32'h0000_1004, 32'hCAFE_F00D);
        step(1'b0, 1'b1, 4'h0, 32'h0000_0004, 32'h0);
`ifdef DATA_SRAM_OOR_ERR_EN
        check("oor_suppressed", obs, 32'h0BAD_F00D);
        check("oor_flag", {31'h0, oor_err}, 32'h1);
        step(1'b0, 1'b1, 4'h0, 32'h0000_1004, 32'h0);
        check("oor_read", obs, 32'hDEAD_BEEF);
`else
        check("alias_read", obs, 32'hCAFE_F00D);
`endif

        step(1'b0, 1'b1, 4'hF, 32'h1FAF_F010, 32'h1234_5678);
        step(1'b0, 1'b1, 4'h0, 32'h1FAF_F010, 32'h0);
        check("scratch_read", obs, 32'h1234_5678);
        step(1'b0, 1'b1, 4'h0, 32'h1FAF_F010, 32'h0);
        step(1'b1, 1'b1, 4'h0, 32'h1FAF_F010, 32'h0);
        check("rst_midread", obs, 32'h0);
        step(1'b1, 1'b1, 4'hF, 32'h1FAF_F010, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 4'h0, 32'h1FAF_F010, 32'h0);
        check("scratch_after_rst", obs, 32'h0);
        idle();
        check("rdata_hold", obs, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Responder (slave) end of the CPU data SRAM interface: accepts en/wen/addr/wdata from the core and returns rdata one cycle later.
- Decodes the address into an on-chip word RAM or a small memory-mapped register region (LED, scratch, free-running timer).
- Used as the data-side memory model in simulation and func-test SoC builds, sitting directly on the core's data_sram_* pins (after the core's mmu virtual-to-physical translation).

Parameters:
- DEPTH_LOG2, 10, RAM depth in 32-bit words (2^DEPTH_LOG2).
- CONF_BASE, 32'h1FAF_0000, base of register region; matched on addr[31:16].
- LED_OFF, 16'hF000, LED register offset (addr[15:0]).
- SCRATCH_OFF, 16'hF010, scratch register offset.
- TIMER_OFF, 16'hE000, timer register offset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_sram_en  input  1  access request this cycle.
- data_sram_wen  input  4  byte write strobes; 0 means read.
- data_sram_addr  input  32  physical byte address; bits [1:0] ignored.
- data_sram_wdata  input  32  write data, byte lanes aligned to strobes.
- data_sram_rdata  output  32  read data, valid the cycle after the request.
- led  output  16  LED register value.
- timer  output  32  current timer value.

Behaviour:
- Reset (rst=1 at edge): rdata=0, led=0, scratch=0, timer=0. RAM contents are not reset.
- Region select: conf_hit = (addr[31:16]==CONF_BASE[31:16]). Otherwise the access targets RAM at word index addr[DEPTH_LOG2+1:2]. Higher address bits are ignored, so RAM aliases (wraps) every 2^DEPTH_LOG2 words.
- Read (en=1, wen=0): rdata at the next edge takes the selected word. Latency is exactly 1 cycle.
- en=0: rdata holds its previous value; no state changes except the timer.
- Write (en=1, wen!=0): each byte lane i is updated only if wen[i]=1. rdata at the next edge returns the OLD contents of the addressed word (read-first semantics).
- Partial strobes apply identically to the RAM and to the registers.
- LED: 16 bits; only lanes 0-1 are meaningful, lanes 2-3 are ignored. Reads return {16'b0, led}.
- Scratch: 32-bit read/write register.
- Timer: increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0.
  - On a write that hits the timer, the masked write value is loaded instead of the increment.
  - Counting resumes from the loaded value on the following cycle.
- Unmapped offsets inside the conf region read 0; writes to them are dropped.
- Back-to-back accesses are allowed every cycle with no stall or ready signal. A write followed by a read of the same address in the next cycle returns the new data.
- rst asserted mid-access: the in-flight rdata is discarded (rdata=0); any write presented in that cycle is ignored.

Optional Feature:
- Macro: DATA_SRAM_OOR_ERR_EN.
- Defined:
  - Adds output oor_err (1 bit, reset 0).
  - Becomes sticky 1 when an en=1 RAM-region access has any nonzero address bit in [31:DEPTH_LOG2+2].
  - The offending write is suppressed; the offending read returns 32'hDEAD_BEEF.
  - Cleared only by rst.
- Undefined: the port is absent and out-of-range addresses alias silently as described above.

Decomposition:
- Shared package: CONF_BASE and the register offset constants, a region-select enum {REG_RAM, REG_LED, REG_SCRATCH, REG_TIMER, REG_NONE}, and the byte-mask merge function (old, new, wen) -> merged word.
- One sub-module: sram_bytewrite_ram, a 2^DEPTH_LOG2 x 32 read-first single-port RAM with 4 byte enables and registered output. The top block handles decode, registers, timer and the output mux.

Test Plan:
- Reset, then read addr 0x1FAF_F000 -> rdata=0 one cycle later; led=0; timer counts 0,1,2,... after rst drops.
- Write 0x1122_3344 to 0x0000_0010 with wen=4'hF; then write 0xAA with wen=4'b0001 to the same address; then read -> rdata=0x1122_33AA. The write cycles return the prior (old) contents.
- Write to LED (0x1FAF_F000) with wdata=0xFFFF_5A5A, wen=4'hF -> led=0x5A5A; read returns 0x0000_5A5A.
- Write timer with 0xFFFF_FFFE -> timer reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on successive cycles.
- Alternate read/write every cycle for 64 cycles against a reference model. Then, with DEPTH_LOG2=10, write addr 0x0000_1004 and read 0x0000_0004 -> same data (alias). With DATA_SRAM_OOR_ERR_EN defined: oor_err=1, the write is suppressed, and reading 0x0000_1004 returns 0xDEAD_BEEF.
- Assert rst during a read of scratch=0x1234_5678 -> rdata=0 and scratch=0 the next cycle.
